// File: rtl/sun_pll_divn_lock_if.sv
// Signal bundle between the SUN PLL feedback divider / lock detector and its surroundings.
// All signals live in the oscillator clock domain, except CK_REF, which is asynchronous.
interface sun_pll_divn_lock_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DIV_N;
    logic             CK_REF;
    logic             CK_FB;
    logic             LOCK;
    logic [WIDTH:0]   MEAS;
    logic             MEAS_VALID;

    modport master (
        output DIV_N,
        output CK_REF,
        input  CK_FB,
        input  LOCK,
        input  MEAS,
        input  MEAS_VALID
    );

    modport slave (
        input  DIV_N,
        input  CK_REF,
        output CK_FB,
        output LOCK,
        output MEAS,
        output MEAS_VALID
    );
endinterface

// File: rtl/sun_pll_divn_lock.sv
// Integer-N feedback divider for the SUN PLL. It also contains a digital lock detector
// that counts CK_REF periods in CK cycles and compares each period against the active ratio.
module sun_pll_divn_lock #(
    parameter int WIDTH      = 8,
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                   CK,
    input  logic                   PWRUP_1V8,
    sun_pll_divn_lock_if.slave     bus
);
    localparam int PW = WIDTH + 1;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [PW-1:0] PCNT_MAX = '1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_req;
    logic             init;
    logic             ck_fb;
    logic             terminal;
    logic             ratio_change;

    logic             ref_s1;
    logic             ref_s2;
    logic             ref_prev;
    logic             ref_rise;
    logic [PW-1:0]    pcnt;
    logic             armed;
    logic [PW-1:0]    meas;
    logic             meas_valid;
    logic [PW-1:0]    n_ext;
    logic [PW-1:0]    diff;
    logic             meas_ev;
    logic             sat_hit;
    logic             good_ev;
    logic             bad_ev;

    lock_state_t      state;
    lock_state_t      state_next;
    logic [GW-1:0]    good_cnt;
    logic [GW-1:0]    good_next;
    logic [BW-1:0]    bad_cnt;
    logic [BW-1:0]    bad_next;
    logic             lock;

    // Ratios below 2 cannot produce a clock, so they are clamped before they are loaded.
    always_comb begin
        n_req        = (bus.DIV_N < WIDTH'(2)) ? WIDTH'(2) : bus.DIV_N;
        terminal     = (cnt == n_act - WIDTH'(1));
        cnt_next     = terminal ? '0 : cnt + WIDTH'(1);
        ratio_change = (init || terminal) && (n_req != n_act);
    end

    always_ff @(posedge CK or negedge PWRUP_1V8) begin
        if (!PWRUP_1V8) begin
            cnt   <= '0;
            n_act <= '0;
            init  <= 1'b1;
            ck_fb <= 1'b0;
        end else if (init) begin
            n_act <= n_req;
            cnt   <= '0;
            ck_fb <= 1'b1;
            init  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            ck_fb <= (cnt_next < (n_act >> 1));
            if (terminal) begin
                n_act <= n_req;
            end
        end
    end

    // The new ratio only affects cycles after cnt wraps to 0, and count 0 is always high,
    // so a ratio change can never produce a runt pulse.
    always_comb begin
        ref_rise = ref_s2 & ~ref_prev;
        n_ext    = PW'(n_act);
        diff     = (pcnt >= n_ext) ? (pcnt - n_ext) : (n_ext - pcnt);
        meas_ev  = ref_rise && armed;
        sat_hit  = armed && !ref_rise && (pcnt == PCNT_MAX - PW'(1));
        good_ev  = meas_ev && (diff <= PW'(LOCK_TOL));
        bad_ev   = (meas_ev && (diff > PW'(LOCK_TOL))) || sat_hit;
    end

    // A saturated count disarms the measurement, so the following edge only restarts it.
    always_ff @(posedge CK or negedge PWRUP_1V8) begin
        if (!PWRUP_1V8) begin
            ref_s1     <= 1'b0;
            ref_s2     <= 1'b0;
            ref_prev   <= 1'b0;
            pcnt       <= '0;
            armed      <= 1'b0;
            meas       <= '0;
            meas_valid <= 1'b0;
        end else begin
            ref_s1     <= bus.CK_REF;
            ref_s2     <= ref_s1;
            ref_prev   <= ref_s2;
            meas_valid <= 1'b0;
            if (ref_rise) begin
                pcnt  <= PW'(1);
                armed <= 1'b1;
                if (armed) begin
                    meas       <= pcnt;
                    meas_valid <= 1'b1;
                end
            end else begin
                if (pcnt != PCNT_MAX) begin
                    pcnt <= pcnt + PW'(1);
                end
                if (sat_hit) begin
                    armed <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        if (ratio_change) begin
            state_next = UNLOCKED;
            good_next  = '0;
            bad_next   = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (good_ev) begin
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state_next = LOCKED;
                            good_next  = '0;
                        end else begin
                            good_next = good_cnt + GW'(1);
                        end
                    end else if (bad_ev) begin
                        good_next = '0;
                    end
                end
                LOCKED: begin
                    if (bad_ev) begin
                        if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
                            state_next = UNLOCKED;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_cnt + BW'(1);
                        end
                    end else if (good_ev) begin
                        bad_next = '0;
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge CK or negedge PWRUP_1V8) begin
        if (!PWRUP_1V8) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            lock     <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            bad_cnt  <= bad_next;
            lock     <= (state_next == LOCKED);
        end
    end

    assign bus.CK_FB      = ck_fb;
    assign bus.LOCK       = lock;
    assign bus.MEAS       = meas;
    assign bus.MEAS_VALID = meas_valid;
endmodule

// File: tb/tb_sun_pll_divn_lock.sv
// Directed bench for sun_pll_divn_lock. Expected MEAS/LOCK pairs are queued as CK_REF edges
// are issued, and a monitor pops one pair on every MEAS_VALID pulse.
module tb_sun_pll_divn_lock;
    logic ck;
    logic pwrup_1v8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   meas;
        logic lock;
        bit   care_meas;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sun_pll_divn_lock_if #(.WIDTH(8)) bus ();

    sun_pll_divn_lock #(
        .WIDTH(8), .LOCK_TOL(2), .LOCK_CNT(16), .UNLOCK_CNT(2)
    ) dut (
        .CK(ck),
        .PWRUP_1V8(pwrup_1v8),
        .bus(bus.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void check_output(input string name, input logic [31:0] actual,
                                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: actual=timeout required=event within budget", name);
    endfunction

    // Monitor: every MEAS_VALID pulse consumes one queued expectation.
    always @(negedge ck) begin
        if (pwrup_1v8 && bus.MEAS_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_meas_valid: actual MEAS=%0d required=no pulse", bus.MEAS);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.care_meas) begin
                    check_output("meas", 32'(bus.MEAS), 32'(mon_e.meas));
                end
                check_output("lock_at_meas", 32'(bus.LOCK), 32'(mon_e.lock));
            end
        end
    end

    task automatic push_exp(input int m, input logic l, input bit c);
        exp_t e;
        e.meas      = m;
        e.lock      = l;
        e.care_meas = c;
        sb.push_back(e);
    endtask

    // Ends with a CK_REF rising edge exactly p CK cycles after the previous one.
    task automatic ref_cycle(input int p);
        repeat (p / 2) @(posedge ck);
        #3 bus.CK_REF = 1'b0;
        repeat (p - p / 2) @(posedge ck);
        #3 bus.CK_REF = 1'b1;
    endtask

    task automatic apply_stimulus(input int p, input logic exp_lock);
        push_exp(p, exp_lock, 1'b1);
        ref_cycle(p);
    endtask

    task automatic flush();
        repeat (8) @(posedge ck);
    endtask

    // The first period after an idle gap has an arbitrary length and is always bad.
    task automatic relock();
        push_exp(0, 1'b0, 1'b0);
        ref_cycle(30);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(8, (i == 15));
        end
        flush();
    endtask

    task automatic wait_fb(input logic v, input string name);
        int t;
        t = 0;
        do begin
            @(negedge ck);
            t++;
        end while (bus.CK_FB !== v && t < 1000);
        if (t >= 1000) timeout_fail(name);
    endtask

    task automatic measure_fb(input string name, input int exp_hi, input int exp_lo);
        int hi;
        int lo;
        wait_fb(1'b0, {name, "_sync_low"});
        wait_fb(1'b1, {name, "_sync_high"});
        hi = 1;
        forever begin
            @(negedge ck);
            if (bus.CK_FB !== 1'b1 || hi > 600) break;
            hi++;
        end
        lo = 1;
        forever begin
            @(negedge ck);
            if (bus.CK_FB !== 1'b0 || lo > 600) break;
            lo++;
        end
        check_output({name, "_high"}, 32'(hi), 32'(exp_hi));
        check_output({name, "_low"}, 32'(lo), 32'(exp_lo));
    endtask

    initial begin
        int   k;
        logic prev_fb;
        logic prev_lock;

        pwrup_1v8  = 1'b0;
        bus.DIV_N  = 8'd8;
        bus.CK_REF = 1'b0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        check_output("reset_ck_fb", 32'(bus.CK_FB), 32'd0);
        check_output("reset_lock", 32'(bus.LOCK), 32'd0);
        check_output("reset_meas", 32'(bus.MEAS), 32'd0);
        check_output("reset_meas_valid", 32'(bus.MEAS_VALID), 32'd0);

        pwrup_1v8 = 1'b1;
        @(posedge ck);
        #1 check_output("fb_first_rise", 32'(bus.CK_FB), 32'd1);

        measure_fb("div8", 4, 4);
        bus.DIV_N = 8'd5;
        measure_fb("div5", 2, 3);
        bus.DIV_N = 8'd0;
        measure_fb("div0", 1, 1);
        bus.DIV_N = 8'd1;
        measure_fb("div1", 1, 1);
        bus.DIV_N = 8'd8;
        measure_fb("div8_again", 4, 4);

        // Arming edge, then 16 good periods: LOCK rises with the 16th pulse.
        @(posedge ck);
        #3 bus.CK_REF = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(8, (i == 15));
        end
        apply_stimulus(12, 1'b1);
        apply_stimulus(10, 1'b1);
        apply_stimulus(12, 1'b1);
        apply_stimulus(11, 1'b0);
        flush();

        // Saturation counts as one bad event; the next edge is discarded.
        relock();
        repeat (600) @(posedge ck);
        @(negedge ck);
        check_output("lock_after_saturation", 32'(bus.LOCK), 32'd1);
        ref_cycle(8);
        apply_stimulus(12, 1'b0);
        flush();

        // Ratio change 8 -> 12 while locked.
        relock();
        check_output("lock_before_ratio_change", 32'(bus.LOCK), 32'd1);
        wait_fb(1'b0, "ratio_sync_low");
        wait_fb(1'b1, "ratio_sync_high");
        bus.DIV_N = 8'd12;
        k = 0;
        prev_fb = 1'b1;
        prev_lock = bus.LOCK;
        forever begin
            @(negedge ck);
            k++;
            if ((prev_fb === 1'b0 && bus.CK_FB === 1'b1) || k > 100) break;
            prev_fb = bus.CK_FB;
            prev_lock = bus.LOCK;
        end
        check_output("old_period_len", 32'(k), 32'd8);
        check_output("lock_before_terminal", 32'(prev_lock), 32'd1);
        check_output("lock_at_terminal", 32'(bus.LOCK), 32'd0);
        measure_fb("div12", 6, 6);

        bus.DIV_N = 8'd8;
        measure_fb("div8_restore", 4, 4);
        relock();
        check_output("lock_before_reset", 32'(bus.LOCK), 32'd1);
        wait_fb(1'b1, "reset_sync_high");
        #1 pwrup_1v8 = 1'b0;
        #1;
        check_output("midreset_lock", 32'(bus.LOCK), 32'd0);
        check_output("midreset_ck_fb", 32'(bus.CK_FB), 32'd0);
        check_output("midreset_meas", 32'(bus.MEAS), 32'd0);
        @(negedge ck);
        pwrup_1v8 = 1'b1;
        @(posedge ck);
        #1 check_output("fb_rise_after_reset", 32'(bus.CK_FB), 32'd1);
        repeat (10) @(posedge ck);
        @(negedge ck);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
